// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transceiver: default bit period,
// frame width and the IDLE/START/DATA/STOP state encoding used by TX and RX.
package uart_pkg;

  // 100 MHz system clock / 10316 cycles per bit, about 9693 baud
  localparam int CLKS_PER_BIT_DEF = 10316;

  // Data bits per frame (8N1)
  localparam int FRAME_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser on rx, mid-bit sampling FSM, and
// data_out/rx_ready. Optional macro UART_FRAME_ERR_EN adds rx_frame_err.
//
// state | meaning
// IDLE  | line high, waiting for a synchronised low
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sample one data bit per bit period, LSB first
// STOP  | sample stop bit; publish byte only if it is high
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  rx_ready
`ifdef UART_FRAME_ERR_EN
  ,
  output logic                  rx_frame_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_BITS - 1);

  logic                  rx_meta;
  logic                  rx_sync;
  uart_state_t           state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [FRAME_BITS-1:0] shift;

  // Bring the asynchronous line into clk; idles high so reset looks like no traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receive FSM; cnt is a down-counter whose terminal count marks mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      data_out <= '0;
      rx_ready <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      rx_frame_err <= 1'b0;
`endif
    end else begin
      rx_ready <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      rx_frame_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_sync) begin
              state <= DATA;
              cnt   <= BIT_LOAD;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift[idx] <= rx_sync;
            cnt        <= BIT_LOAD;
            if (idx == LAST_IDX) state <= STOP;
            else                 idx   <= idx + IW'(1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STOP: begin
          if (cnt == '0) begin
            // Back to IDLE right away so a start edge right after the stop bit is seen
            state <= IDLE;
            if (rx_sync) begin
              data_out <= shift;
              rx_ready <= 1'b1;
            end
`ifdef UART_FRAME_ERR_EN
            else begin
              rx_frame_err <= 1'b1;
            end
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: inline transmitter plus uart_rx receiver, timed by
// counting clk cycles. Optional macro UART_FRAME_ERR_EN adds rx_frame_err.
//
// state | meaning
// IDLE  | tx_out high, waiting for start; captures data on start
// START | drive start bit (0) for one bit period
// DATA  | drive shift[0], shift right each bit period, 8 bits
// STOP  | drive stop bit (1) for one bit period, then IDLE
module uart_top import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] data,
  output logic                  tx_out,
  input  logic                  rx,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  rx_ready
`ifdef UART_FRAME_ERR_EN
  ,
  output logic                  rx_frame_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BITS - 1);

  uart_state_t           tx_state;
  logic [CW-1:0]         tx_cnt;
  logic [IW-1:0]         tx_idx;
  logic [FRAME_BITS-1:0] tx_shift;

  // Transmit FSM; tx_out is registered so each bit lasts exactly one bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_out   <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          tx_out <= 1'b1;
          if (start) begin
            tx_shift <= data;
            tx_out   <= 1'b0;
            tx_cnt   <= BIT_LOAD;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == '0) begin
            tx_out   <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_idx   <= '0;
            tx_cnt   <= BIT_LOAD;
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LOAD;
            if (tx_idx == LAST_IDX) begin
              tx_out   <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_out   <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_idx   <= tx_idx + IW'(1);
            end
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        STOP: begin
          if (tx_cnt == '0) tx_state <= IDLE;
          else              tx_cnt   <= tx_cnt - CW'(1);
        end
        default: begin
          tx_out   <= 1'b1;
          tx_state <= IDLE;
        end
      endcase
    end
  end

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .data_out     (data_out),
    .rx_ready     (rx_ready)
`ifdef UART_FRAME_ERR_EN
    ,
    .rx_frame_err (rx_frame_err)
`endif
  );

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top with a short bit period.
module tb_uart_top;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] data;
  logic       tx_out;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_ready;
`ifdef UART_FRAME_ERR_EN
  logic       rx_frame_err;
  int         err_cnt = 0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_cnt = 0;
  int rdy_cyc = 0;
  logic [7:0] rdy_data = 8'h00;

  uart_top #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data     (data),
    .tx_out   (tx_out),
    .rx       (rx),
    .data_out (data_out),
    .rx_ready (rx_ready)
`ifdef UART_FRAME_ERR_EN
    ,
    .rx_frame_err (rx_frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst_n && rx_ready) begin
      rdy_cnt  = rdy_cnt + 1;
      rdy_data = data_out;
      rdy_cyc  = cyc;
    end
`ifdef UART_FRAME_ERR_EN
    if (rst_n && rx_frame_err) err_cnt = err_cnt + 1;
`endif
  end

  // Drives one frame on rx starting now (caller is at a negedge); returns start cycle
  task automatic send_rx(input logic [7:0] b, input logic stop_bit, output int t0);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; data = 8'h00; rx = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL reset_tx_out got=%b exp=1", tx_out); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL idle_tx_out got=%b exp=1", tx_out); end
  endtask

  task automatic test_transmit;
    logic [9:0] fr;
    fr = {1'b1, 8'hAE, 1'b0};
    @(negedge clk); data = 8'hAE; start = 1'b1;
    @(posedge clk); #1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 10 * CPB; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        if (k == 3 * CPB) data = 8'h00;
        if (k == 9 * CPB) data = 8'hAE;
        if (f == 1 && k == 5 * CPB) start = 1'b0;
        total++;
        if (tx_out !== fr[k / CPB]) begin
          bad++; $display("FAIL tx_frame%0d_k%0d got=%b exp=%b", f, k, tx_out, fr[k / CPB]);
        end
      end
      if (f == 0) begin
        @(posedge clk); #1;
        total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL tx_gap got=%b exp=1", tx_out); end
        @(posedge clk); #1;
      end
    end
    repeat (2 * CPB) begin
      @(posedge clk); #1;
      total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL tx_after got=%b exp=1", tx_out); end
    end
  endtask

  task automatic test_receive;
    int base, t0;
    base = rdy_cnt;
    @(negedge clk);
    send_rx(8'h75, 1'b1, t0);
    repeat (CPB) @(negedge clk);
    total++; if (rdy_cnt - base !== 1) begin bad++; $display("FAIL rx_pulses got=%0d exp=1", rdy_cnt - base); end
    total++; if (rdy_data !== 8'h75) begin bad++; $display("FAIL rx_data_at_ready got=%h exp=75", rdy_data); end
    total++; if (data_out !== 8'h75) begin bad++; $display("FAIL rx_data_hold got=%h exp=75", data_out); end
    total++;
    if (rdy_cyc - t0 < 9 * CPB + CPB / 2 + 1 || rdy_cyc - t0 > 9 * CPB + CPB / 2 + 5) begin
      bad++; $display("FAIL rx_latency got=%0d exp=%0d..%0d", rdy_cyc - t0, 9 * CPB + CPB / 2 + 1, 9 * CPB + CPB / 2 + 5);
    end
  endtask

  task automatic test_glitch;
    int base, t0;
    base = rdy_cnt;
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    total++; if (rdy_cnt - base !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", rdy_cnt - base); end
    total++; if (data_out !== 8'h75) begin bad++; $display("FAIL glitch_data got=%h exp=75", data_out); end
    send_rx(8'hA5, 1'b1, t0);
    repeat (CPB) @(negedge clk);
    total++; if (rdy_cnt - base !== 1) begin bad++; $display("FAIL after_glitch_pulses got=%0d exp=1", rdy_cnt - base); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL after_glitch_data got=%h exp=a5", data_out); end
  endtask

  task automatic test_framing;
    int base, t0;
`ifdef UART_FRAME_ERR_EN
    int ebase;
    ebase = err_cnt;
`endif
    base = rdy_cnt;
    @(negedge clk);
    send_rx(8'h3C, 1'b0, t0);
    repeat (2 * CPB) @(negedge clk);
    total++; if (rdy_cnt - base !== 0) begin bad++; $display("FAIL frame_err_pulses got=%0d exp=0", rdy_cnt - base); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL frame_err_data got=%h exp=a5", data_out); end
`ifdef UART_FRAME_ERR_EN
    total++; if (err_cnt - ebase !== 1) begin bad++; $display("FAIL frame_err_flag got=%0d exp=1", err_cnt - ebase); end
`endif
  endtask

  task automatic test_back_to_back;
    int base, t0;
    base = rdy_cnt;
    @(negedge clk);
    send_rx(8'h81, 1'b1, t0);
    total++; if (data_out !== 8'h81) begin bad++; $display("FAIL b2b_first got=%h exp=81", data_out); end
    send_rx(8'h42, 1'b1, t0);
    repeat (CPB) @(negedge clk);
    total++; if (rdy_cnt - base !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", rdy_cnt - base); end
    total++; if (data_out !== 8'h42) begin bad++; $display("FAIL b2b_second got=%h exp=42", data_out); end
  endtask

  task automatic test_reset_mid_tx;
    logic [9:0] fr;
    @(negedge clk); data = 8'h5A; start = 1'b1;
    repeat (CPB + CPB / 2) @(negedge clk);
    total++; if (tx_out !== 1'b0) begin bad++; $display("FAIL mid_tx_bit got=%b exp=0", tx_out); end
    start = 1'b0; rst_n = 1'b0; #1;
    total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL mid_tx_reset got=%b exp=1", tx_out); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_tx_reset_data got=%h exp=00", data_out); end
    repeat (3) @(negedge clk);
    data = 8'hC3; start = 1'b1; rst_n = 1'b1;
    fr = {1'b1, 8'hC3, 1'b0};
    @(posedge clk); #1;
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 2) start = 1'b0;
      total++;
      if (tx_out !== fr[k / CPB]) begin
        bad++; $display("FAIL restart_k%0d got=%b exp=%b", k, tx_out, fr[k / CPB]);
      end
    end
    repeat (CPB) begin
      @(posedge clk); #1;
      total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL restart_idle got=%b exp=1", tx_out); end
    end
  endtask

  initial begin
    test_reset;
    test_transmit;
    test_receive;
    test_glitch;
    test_framing;
    test_back_to_back;
    test_reset_mid_tx;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
